// File: rtl/board_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_pkg
// Description : Shared constants and types for the game-board cell memory.
//               Holds the board geometry, the cell width, the default value
//               written by the clear sequencer and the controller state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package board_mem_pkg;

    // Board geometry: 16 x 16 cells, one byte per cell, row-major layout.
    localparam int BOARD_DIM   = 16;
    localparam int CELL_W      = 8;
    localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;

    // Value every cell takes after a clear.
    localparam logic [CELL_W-1:0] DEF_CLEAR_VAL = 8'h00;

    // Controller states. The encoding is fixed so that it stays compatible
    // with older netlists that decode the raw state bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        CLEAR = 2'd2
    } board_mem_state_t;

endpackage : board_mem_pkg
`default_nettype wire

// File: rtl/board_mem_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_if
// Description : Classic single-beat Wishbone bus between the board-logic
//               master and the board memory. Signal names follow the
//               master's point of view (_O driven by master, _I by slave).
// Ports       : CLK_I   in  bus clock, tied to the system clock net
//   Signals   : ADR_O, DAT_O, WE_O, STB_O, CYC_O  master -> slave
//               DAT_I, ACK_I                      slave  -> master
// Modports    : master, slave
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_if
    import board_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = CELL_W
) (
    input logic CLK_I
);

    logic [ADDR_W-1:0] ADR_O;
    logic [DATA_W-1:0] DAT_O;
    logic              WE_O;
    logic              STB_O;
    logic              CYC_O;
    logic [DATA_W-1:0] DAT_I;
    logic              ACK_I;

    modport master (
        input  CLK_I,
        output ADR_O,
        output DAT_O,
        output WE_O,
        output STB_O,
        output CYC_O,
        input  DAT_I,
        input  ACK_I
    );

    modport slave (
        input  CLK_I,
        input  ADR_O,
        input  DAT_O,
        input  WE_O,
        input  STB_O,
        input  CYC_O,
        output DAT_I,
        output ACK_I
    );

endinterface : wishbone_if
`default_nettype wire

// File: rtl/board_mem_wb_ram.sv
`default_nettype none
// ============================================================================
// Module      : board_ram
// Description : Single-port synchronous RAM with a registered read port,
//               written in the canonical form for block-RAM inference.
//               Contents are deliberately not reset.
// Ports       : clk       in  clock
//               we_i      in  write enable
//               addr_i    in  cell address
//               wdata_i   in  write data
//               rdata_o   out registered read data (mem[addr_i] of the
//                             previous cycle, read-before-write)
// Revision    : 1.0 - initial release
// ============================================================================
module board_ram
    import board_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = CELL_W,
    parameter int DEPTH  = BOARD_CELLS
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule : board_ram
`default_nettype wire

// File: rtl/board_mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_wb
// Description : Wishbone slave holding the 16x16 game board (256 x 8 cells).
//               Serves single reads/writes and runs a clear sequencer that
//               rewrites every cell with CLEAR_VAL before a new game.
// Ports       : clk         in  system clock (also drives wb.CLK_I)
//               rst_n       in  asynchronous active-low reset
//               wb          io  wishbone_if.slave bus port
//               clear_req   in  single-cycle clear request
//               busy        out high while a clear is in progress
//               clear_done  out single-cycle pulse at clear completion
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_wb
    import board_mem_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = CELL_W,
    parameter int                DEPTH     = BOARD_CELLS,   // must be 2**ADDR_W
    parameter logic [DATA_W-1:0] CLEAR_VAL = DEF_CLEAR_VAL
) (
    input  logic       clk,
    input  logic       rst_n,
    wishbone_if.slave  wb,
    input  logic       clear_req,
    output logic       busy,
    output logic       clear_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    board_mem_state_t  state_q,    state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_pend_q, clr_pend_d;
    logic              we_q,       we_d;
    logic              ack_q,      ack_d;
    logic [DATA_W-1:0] dat_q,      dat_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_req;
    logic w_clear_go;
    logic w_accept;

    assign w_req      = wb.CYC_O && wb.STB_O;
    // A clear (new or deferred from an ACK cycle) wins over a bus request;
    // the master simply keeps STB_O asserted until the clear finishes.
    assign w_clear_go = (state_q == IDLE) && (clear_req || clr_pend_q);
    assign w_accept   = (state_q == IDLE) && w_req && !w_clear_go;

    // ------------------------------------------------------------------
    // RAM port mux: the clear sequencer owns the port while clearing.
    // ------------------------------------------------------------------
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    always_comb begin
        if (state_q == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = clr_addr_q;
            w_ram_wdata = CLEAR_VAL;
        end else begin
            w_ram_we    = w_accept && wb.WE_O;
            w_ram_addr  = wb.ADR_O;
            w_ram_wdata = wb.DAT_O;
        end
    end

    board_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .addr_i  (w_ram_addr),
        .wdata_i (w_ram_wdata),
        .rdata_o (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_pend_d = clr_pend_q;
        we_d       = we_q;

        case (state_q)
            IDLE: begin
                if (w_clear_go) begin
                    state_d    = CLEAR;
                    clr_pend_d = 1'b0;
                end else if (w_accept) begin
                    state_d = ACK;
                    we_d    = wb.WE_O;
                end
            end
            ACK: begin
                // The transaction completes regardless of CYC_O here.
                state_d = IDLE;
                if (clear_req) begin
                    clr_pend_d = 1'b1;
                end
            end
            CLEAR: begin
                // clear_req is ignored here; the running clear is not restarted.
                // The counter wraps from LAST_ADDR back to 0 on its own.
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The RAM output register captured mem[ADR_O] at the accept edge, so in
    // ACK it already holds the read data; DAT_I only loads it for reads and
    // otherwise keeps the last value read.
    assign ack_d  = (state_q == ACK);
    assign dat_d  = ((state_q == ACK) && !we_q) ? w_ram_rdata : dat_q;
    // busy trails the CLEAR state by one cycle, so it falls together with
    // the clear_done pulse, one edge after the last cell write.
    assign busy_d = (state_q == CLEAR);
    assign done_d = (state_q == CLEAR) && (clr_addr_q == LAST_ADDR);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            clr_pend_q <= 1'b0;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_pend_q <= clr_pend_d;
            we_q       <= we_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb.ACK_I   = ack_q;
    assign wb.DAT_I   = dat_q;
    assign busy       = busy_q;
    assign clear_done = done_q;

endmodule : board_mem_wb
`default_nettype wire

// File: tb/tb_board_mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_mem_wb
// Description : Self-checking bench for board_mem_wb. Bus transactions push
//               their expected response into a scoreboard queue; a separate
//               monitor pops and compares on every ACK_I.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_mem_wb;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_req;
    logic busy;
    logic clear_done;

    always #5 clk = ~clk;

    wishbone_if #(.ADDR_W(8), .DATA_W(8)) wb (.CLK_I(clk));

    board_mem_wb #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .DEPTH     (256),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wb),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       we;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_dat = 8'h00;   // expected DAT_I between transactions

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: every ACK_I must match the oldest scoreboard entry and last
    // exactly one cycle.
    // ------------------------------------------------------------------
    logic prev_ack = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && wb.ACK_I !== 1'b0) begin
            check("ack_single_cycle", {31'd0, prev_ack}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ACK_I=%b, expected no ACK", wb.ACK_I);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_dat"}, {24'd0, wb.DAT_I}, {24'd0, e.data});
            end
        end
        prev_ack = (wb.ACK_I === 1'b1);
    end

    // ------------------------------------------------------------------
    // Master: one Wishbone transaction, optionally with clear_req raised in
    // the same cycle. Latency counts edges from request sample to ACK.
    // ------------------------------------------------------------------
    task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] data,
                        input int exp_lat, input bit with_clear, input string name);
        exp_t e;
        int   t_req;
        int   lat;
        bit   got;
        e.we   = we;
        e.name = name;
        if (we) begin
            e.data = model_dat;
        end else begin
            e.data    = data;
            model_dat = data;
        end
        sb.push_back(e);
        @(negedge clk);
        wb.ADR_O  = addr;
        wb.DAT_O  = we ? data : 8'h00;
        wb.WE_O   = we;
        wb.STB_O  = 1'b1;
        wb.CYC_O  = 1'b1;
        if (with_clear) clear_req = 1'b1;
        t_req = cyc + 1;
        got   = 1'b0;
        lat   = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            clear_req = 1'b0;
            if (wb.ACK_I === 1'b1) begin
                got = 1'b1;
                lat = cyc - t_req;
            end
        end
        wb.STB_O = 1'b0;
        wb.CYC_O = 1'b0;
        wb.WE_O  = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no ACK_I in 400 cycles, expected latency %0d", name, exp_lat);
        end else begin
            check({name, "_lat"}, lat, exp_lat);
        end
    endtask

    // Pulse clear_req in IDLE and observe busy/clear_done for 300 edges.
    task automatic do_clear(input string name);
        int t0;
        int bcnt;
        int dcnt;
        int doff;
        bcnt = 0;
        dcnt = 0;
        doff = -1;
        @(negedge clk);
        clear_req = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        check({name, "_busy_at_req_edge"}, {31'd0, busy}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) bcnt++;
            if (clear_done === 1'b1) begin
                dcnt++;
                doff = cyc - t0;
            end
        end
        check({name, "_busy_cycles"}, bcnt, 256);
        check({name, "_done_pulses"}, dcnt, 1);
        check({name, "_done_edge"}, doff, 256);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"},  {31'd0, wb.ACK_I},   32'd0);
        check({name, "_dat"},  {24'd0, wb.DAT_I},   32'd0);
        check({name, "_busy"}, {31'd0, busy},       32'd0);
        check({name, "_done"}, {31'd0, clear_done}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int t0;
        rst_n     = 1'b0;
        clear_req = 1'b0;
        wb.ADR_O  = 8'h00;
        wb.DAT_O  = 8'h00;
        wb.WE_O   = 1'b0;
        wb.STB_O  = 1'b0;
        wb.CYC_O  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read-back.
        xfer(1'b1, 8'h3C, 8'hA5, 1, 1'b0, "wr_3C");
        xfer(1'b0, 8'h3C, 8'hA5, 1, 1'b0, "rd_3C");

        // Mid-simulation asynchronous reset: DAT_I drops from A5 to 0.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n     = 1'b1;
        model_dat = 8'h00;

        // Address boundaries, with a neighbour to catch aliasing.
        xfer(1'b1, 8'h00, 8'h11, 1, 1'b0, "wr_00");
        xfer(1'b1, 8'hFF, 8'hFF, 1, 1'b0, "wr_FF");
        xfer(1'b1, 8'h80, 8'h42, 1, 1'b0, "wr_80");
        xfer(1'b0, 8'h00, 8'h11, 1, 1'b0, "rd_00");
        xfer(1'b0, 8'hFF, 8'hFF, 1, 1'b0, "rd_FF");
        xfer(1'b0, 8'h80, 8'h42, 1, 1'b0, "rd_80");

        // Full clear.
        do_clear("clr1");
        xfer(1'b0, 8'h00, 8'h00, 1, 1'b0, "clr1_rd_00");
        xfer(1'b0, 8'h80, 8'h00, 1, 1'b0, "clr1_rd_80");
        xfer(1'b0, 8'hFF, 8'h00, 1, 1'b0, "clr1_rd_FF");

        // Contention: clear and read in the same IDLE cycle; the read waits
        // for the clear and sees the cleared value.
        xfer(1'b1, 8'h80, 8'h77, 1, 1'b0, "wr_80b");
        xfer(1'b0, 8'h80, 8'h77, 1, 1'b0, "rd_80b");
        xfer(1'b0, 8'h80, 8'h00, 258, 1'b1, "contend_rd_80");

        // Reset in the middle of a clear, then a clean clear.
        xfer(1'b1, 8'h10, 8'h5A, 1, 1'b0, "wr_10");
        xfer(1'b1, 8'hF0, 8'h5A, 1, 1'b0, "wr_F0");
        @(negedge clk);
        clear_req = 1'b1;
        t0 = cyc + 1;
        for (int i = 0; i < 200 && (cyc - t0) < 100; i++) begin
            @(posedge clk);
            #1;
            clear_req = 1'b0;
        end
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n     = 1'b1;
        model_dat = 8'h00;
        do_clear("clr2");
        xfer(1'b0, 8'h10, 8'h00, 1, 1'b0, "clr2_rd_10");
        xfer(1'b0, 8'hF0, 8'h00, 1, 1'b0, "clr2_rd_F0");

        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_board_mem_wb
`default_nettype wire
